// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: frame width, FSM state encoding,
// opcode encoding and the last data-phase bit index.
package spi_pkg;

  localparam int FRAME_W = 10;

  // Index of the final DATA cycle (bit counter value that ends the phase).
  localparam logic [3:0] DATA_LAST = 4'(FRAME_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CMD,
    ST_DATA,
    ST_END
  } state_e;

  // Frame bits [9:8].
  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;

endpackage

// File: rtl/spi_master_if.sv
// Command handshake, read-back and serial pins of the SPI master.
// The master modport is the RTL view; the slave modport is the
// requester/peripheral view.
interface spi_master_if;
  import spi_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [FRAME_W-1:0] cmd_frame;
  logic               SS_n;
  logic               MOSI;
  logic               MISO;
  logic [7:0]         rd_data;
  logic               rd_valid;
  logic               done;
  logic               busy;

  modport master (
    input  cmd_valid, cmd_frame, MISO,
    output cmd_ready, SS_n, MOSI, rd_data, rd_valid, done, busy
  );

  modport slave (
    output cmd_valid, cmd_frame, MISO,
    input  cmd_ready, SS_n, MOSI, rd_data, rd_valid, done, busy
  );

endinterface

// File: rtl/spi_shift_reg.sv
// Parallel-load, MSB-first shift register. Load has priority over shift;
// the serial input enters at bit 0, so the MSB is the next bit out.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int W = FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q, data_d;

  // Next value: load, shift left by one, or hold.
  always_comb begin
    // NOTE: default first so every path assigns data_d and no latch is inferred.
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = {data_q[W-2:0], ser_i};
    end
  end

  // Shift register state with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/spi_master.sv
// SPI master: accepts 10-bit frames on a valid/ready handshake and sends
// them as SEL, CMD, 10 DATA cycles, END. Read-data frames capture one byte
// from MISO starting at data cycle MISO_OFS. All outputs are registered and
// computed from the next state, so they change on the edge entering a state.
// Optional build macro SPI_MASTER_GAP_EN stretches END to GAP cycles.
module spi_master
  import spi_pkg::*;
#(
  parameter int MISO_OFS = 1,
  parameter int GAP      = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  localparam logic [3:0] SAMPLE_FIRST = 4'(MISO_OFS);

  state_e             state_q, state_d;
  opcode_e            op_q, op_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_valid_q, rd_valid_d;
  logic [7:0]         rd_data_q, rd_data_d;

  logic               handshake;
  logic               data_last;
  logic               end_last;
  logic               sample_en;
  logic [FRAME_W-1:0] tx_data;
  logic [FRAME_W-1:0] rx_data;
  logic               unused_bits;

  assign handshake = (state_q == ST_IDLE) && ready_q && bus.cmd_valid;
  assign data_last = (state_q == ST_DATA) && (cnt_q == DATA_LAST);
  // Wrapping subtraction keeps counts below the offset out of the window.
  assign sample_en = (state_q == ST_DATA) && (op_q == OP_RD_DATA) &&
                     ((cnt_q - SAMPLE_FIRST) < 4'd8);

  // Outgoing frame: loaded on handshake, advanced once per DATA cycle.
  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk         (clk),
    .rst         (rst),
    .load_i      (handshake),
    .load_data_i (bus.cmd_frame),
    .shift_i     (state_q == ST_DATA),
    .ser_i       (1'b0),
    .data_o      (tx_data)
  );

  // Incoming byte: cleared on handshake, shifted only inside the MISO window.
  spi_shift_reg #(.W(FRAME_W)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .load_i      (handshake),
    .load_data_i ('0),
    .shift_i     (sample_en),
    .ser_i       (bus.MISO),
    .data_o      (rx_data)
  );

  // Only the top two transmit bits and the low receive byte are consumed.
  assign unused_bits = ^{tx_data[FRAME_W-3:0], rx_data[FRAME_W-1:8]};

`ifdef SPI_MASTER_GAP_EN
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  logic [GAP_W-1:0] gap_q, gap_d;

  assign end_last = (gap_q == GAP_W'(GAP - 1));

  // END dwell counter: runs in END, cleared everywhere else.
  always_comb begin
    gap_d = '0;
    if (state_q == ST_END) begin
      gap_d = gap_q + 1'b1;
    end
  end

  // END dwell counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign end_last = 1'b1;
`endif

  // Next-state logic of the frame sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (handshake) state_d = ST_SEL;
      ST_SEL:  state_d = ST_CMD;
      ST_CMD:  state_d = ST_DATA;
      ST_DATA: if (data_last) state_d = ST_END;
      ST_END:  if (end_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and datapath, derived from the state being entered.
  always_comb begin
    op_d       = handshake ? opcode_e'(bus.cmd_frame[FRAME_W-1:FRAME_W-2]) : op_q;

    cnt_d      = cnt_q;
    if (state_q == ST_CMD) begin
      cnt_d = '0;
    end else if ((state_q == ST_DATA) && !data_last) begin
      cnt_d = cnt_q + 4'd1;
    end

    ss_n_d     = !(state_d inside {ST_SEL, ST_CMD, ST_DATA});

    // CMD and DATA k=0 both carry frame[9]; later DATA cycles take the bit
    // behind the MSB, since the shifter advances on the same edge.
    mosi_d     = 1'b0;
    if (state_d == ST_CMD) begin
      mosi_d = tx_data[FRAME_W-1];
    end else if (state_d == ST_DATA) begin
      mosi_d = (state_q == ST_CMD) ? tx_data[FRAME_W-1] : tx_data[FRAME_W-2];
    end

    ready_d    = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = data_last;
    rd_valid_d = data_last && (op_q == OP_RD_DATA);

    // The last window sample may land on this very edge, so fold it in.
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = sample_en ? {rx_data[6:0], bus.MISO} : rx_data[7:0];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WR_ADDR;
      cnt_q      <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed testbench for spi_master. Three instances (MISO_OFS = 0, 1, 2)
// share the command stimulus; each has its own slave model that returns
// slave_byte in its MISO window and slave_noise everywhere else.
// Instance 1 (default offset) is the one checked for framing and timing.
`timescale 1ns/1ps
module tb_spi_master;

`ifdef SPI_MASTER_GAP_EN
  localparam int END_LEN = 4;
`else
  localparam int END_LEN = 1;
`endif
  localparam int FRAME_CYC = 12 + END_LEN;  // SEL through last END cycle
  localparam int PERIOD    = 13 + END_LEN;  // handshake spacing, valid held

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_frame = '0;
  logic [7:0] slave_byte = '0;
  logic       slave_noise = 1'b0;

  logic [2:0] ss_n, mosi, cmd_ready, rd_valid, done, busy;
  logic [7:0] rd_data [3];

  logic       tr_ss   [64];
  logic       tr_mosi [64];
  logic       tr_done [64];
  logic       tr_rdv  [64];
  logic       tr_busy [64];
  logic       tr_rdy  [64];
  logic [7:0] tr_rdd  [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_master_if bus ();
    int pos;

    spi_master #(.MISO_OFS(g), .GAP(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
    );

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_frame = cmd_frame;
    assign ss_n[g]       = bus.SS_n;
    assign mosi[g]       = bus.MOSI;
    assign cmd_ready[g]  = bus.cmd_ready;
    assign rd_valid[g]   = bus.rd_valid;
    assign done[g]       = bus.done;
    assign busy[g]       = bus.busy;
    assign rd_data[g]    = bus.rd_data;

    // Slave: pos 0 = SEL, 1 = CMD, data cycle k at pos k+2.
    always @(negedge clk) begin : slave_model
      int k;
      if (bus.SS_n !== 1'b0) begin
        pos      = 0;
        bus.MISO = slave_noise;
      end else begin
        k = pos - 2;
        if (k >= g && k <= g + 7) bus.MISO = slave_byte[7 - (k - g)];
        else                      bus.MISO = slave_noise;
        pos = pos + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready[1] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready: cmd_ready=%b required 1 within 100 cycles", cmd_ready[1]);
    end
  endtask

  // Returns at the negedge inside SEL of the accepted frame.
  task automatic send(input logic [9:0] f);
    wait_ready();
    cmd_valid = 1'b1;
    cmd_frame = f;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      tr_ss[i]   = ss_n[1];
      tr_mosi[i] = mosi[1];
      tr_done[i] = done[1];
      tr_rdv[i]  = rd_valid[1];
      tr_busy[i] = busy[1];
      tr_rdy[i]  = cmd_ready[1];
      tr_rdd[i]  = rd_data[1];
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ss_n !== 3'b111) begin errors++; $display("FAIL reset_ss_n: got %b required 111", ss_n); end
    checks++;
    if (mosi !== 3'b000) begin errors++; $display("FAIL reset_mosi: got %b required 000", mosi); end
    checks++;
    if (cmd_ready !== 3'b000) begin errors++; $display("FAIL reset_cmd_ready: got %b required 000", cmd_ready); end
    checks++;
    if ({busy, done, rd_valid} !== 9'b0) begin
      errors++; $display("FAIL reset_flags: busy/done/rd_valid got %b required 0", {busy, done, rd_valid});
    end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (rd_data[g] !== 8'h00) begin errors++; $display("FAIL reset_rd_data[%0d]: got %h required 00", g, rd_data[g]); end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 3'b111) begin errors++; $display("FAIL reset_release_ready: got %b required 111", cmd_ready); end
  endtask

  task automatic test_write_addr();
    logic [12:0] exp_mosi = 13'b00_0010100101_0;  // SEL, CMD, DATA k=0..9, END
    logic [12:0] got_mosi;
    logic [12:0] got_ss;
    int lows = 0, dones = 0, rdvs = 0, busy_bad = 0;
    slave_byte  = 8'hFF;
    slave_noise = 1'b1;
    send(10'b00_1010_0101);
    capture(FRAME_CYC + 3);
    for (int i = 0; i < 13; i++) begin
      got_mosi[12 - i] = tr_mosi[i];
      got_ss[12 - i]   = tr_ss[i];
    end
    for (int i = 0; i < FRAME_CYC + 3; i++) begin
      if (tr_ss[i] === 1'b0) lows++;
      if (tr_done[i] === 1'b1) dones++;
      if (tr_rdv[i] === 1'b1) rdvs++;
      if (tr_busy[i] !== (i < FRAME_CYC)) busy_bad++;
    end
    checks++;
    if (got_mosi !== exp_mosi) begin errors++; $display("FAIL wr_mosi_seq: got %b required %b", got_mosi, exp_mosi); end
    checks++;
    if (got_ss !== 13'b0000000000001) begin errors++; $display("FAIL wr_ss_pattern: got %b required 0000000000001", got_ss); end
    checks++;
    if (lows != 12) begin errors++; $display("FAIL wr_ss_low_count: got %0d required 12", lows); end
    checks++;
    if (dones != 1 || tr_done[12] !== 1'b1) begin
      errors++; $display("FAIL wr_done: count %0d, at END %b, required 1 and 1", dones, tr_done[12]);
    end
    checks++;
    if (rdvs != 0) begin errors++; $display("FAIL wr_no_rd_valid: got %0d pulses required 0", rdvs); end
    checks++;
    if (busy_bad != 0) begin errors++; $display("FAIL wr_busy: %0d cycles wrong, required 0", busy_bad); end
    checks++;
    if (tr_rdy[FRAME_CYC] !== 1'b1 || tr_rdy[5] !== 1'b0) begin
      errors++; $display("FAIL wr_cmd_ready: mid-frame %b after END %b, required 0 and 1", tr_rdy[5], tr_rdy[FRAME_CYC]);
    end
    checks++;
    if (rd_data[1] !== 8'h00) begin errors++; $display("FAIL wr_rd_data_hold: got %h required 00", rd_data[1]); end
  endtask

  task automatic test_read_data();
    int dones = 0, rdvs = 0;
    slave_byte  = 8'hC3;
    slave_noise = 1'b0;
    send(10'b11_0000_0000);
    capture(FRAME_CYC + 3);
    for (int i = 0; i < FRAME_CYC + 3; i++) begin
      if (tr_done[i] === 1'b1) dones++;
      if (tr_rdv[i] === 1'b1) rdvs++;
    end
    checks++;
    if (tr_rdv[12] !== 1'b1 || tr_done[12] !== 1'b1) begin
      errors++; $display("FAIL rd_coincident: rd_valid %b done %b at END, required 1 1", tr_rdv[12], tr_done[12]);
    end
    checks++;
    if (tr_rdd[12] !== 8'hC3) begin errors++; $display("FAIL rd_data_at_valid: got %h required c3", tr_rdd[12]); end
    checks++;
    if (tr_rdd[11] !== 8'h00) begin errors++; $display("FAIL rd_data_early: got %h required 00 before END", tr_rdd[11]); end
    checks++;
    if (dones != 1 || rdvs != 1) begin
      errors++; $display("FAIL rd_pulse_count: done %0d rd_valid %0d, required 1 1", dones, rdvs);
    end
    checks++;
    if (rd_data[1] !== 8'hC3) begin errors++; $display("FAIL rd_data_hold: got %h required c3", rd_data[1]); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] fa = 10'b01_0011_1100;
    logic [9:0] fb = 10'b00_1100_0011;
    int n = PERIOD + FRAME_CYC + 3;
    int ss_bad = 0, mosi_bad = 0, done_bad = 0, rdy_bad = 0, first_low = -1;
    logic exp_ss;
    slave_byte  = 8'h77;
    slave_noise = 1'b1;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_frame = fa;
    @(negedge clk);
    cmd_frame = fb;  // valid stays high; must not disturb the running frame
    for (int i = 0; i < n; i++) begin
      tr_ss[i]   = ss_n[1];
      tr_mosi[i] = mosi[1];
      tr_done[i] = done[1];
      tr_rdy[i]  = cmd_ready[1];
      if (i == PERIOD) cmd_valid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      exp_ss = !((i < 12) || (i >= PERIOD && i < PERIOD + 12));
      if (tr_ss[i] !== exp_ss) ss_bad++;
      if (tr_done[i] !== (i == 12 || i == PERIOD + 12)) done_bad++;
      if (i >= 12 && first_low < 0 && tr_ss[i] === 1'b0) first_low = i;
      if (i < 12 && tr_rdy[i] !== 1'b0) rdy_bad++;
    end
    for (int k = 0; k < 10; k++) begin
      if (tr_mosi[k + 2] !== fa[9 - k]) mosi_bad++;
      if (tr_mosi[PERIOD + k + 2] !== fb[9 - k]) mosi_bad++;
    end
    checks++;
    if (first_low != PERIOD) begin errors++; $display("FAIL b2b_second_sel: at cycle %0d required %0d", first_low, PERIOD); end
    checks++;
    if (ss_bad != 0) begin errors++; $display("FAIL b2b_ss_pattern: %0d cycles wrong, required 0", ss_bad); end
    checks++;
    if (mosi_bad != 0) begin errors++; $display("FAIL b2b_mosi: %0d bits wrong, required 0", mosi_bad); end
    checks++;
    if (done_bad != 0) begin errors++; $display("FAIL b2b_done: %0d cycles wrong, required 0", done_bad); end
    checks++;
    if (rdy_bad != 0) begin errors++; $display("FAIL b2b_ready_busy: %0d cycles ready while busy, required 0", rdy_bad); end
    checks++;
    if (rd_data[1] !== 8'hC3) begin errors++; $display("FAIL b2b_rd_data_hold: got %h required c3", rd_data[1]); end
  endtask

  task automatic test_miso_ofs();
    for (int r = 0; r < 2; r++) begin
      slave_byte  = 8'h5A;
      slave_noise = (r == 0);
      send(10'b11_0101_0101);
      repeat (FRAME_CYC + 2) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (rd_data[g] !== 8'h5A) begin
          errors++; $display("FAIL ofs%0d_noise%0d: rd_data got %h required 5a", g, slave_noise, rd_data[g]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    slave_byte  = 8'h3C;
    slave_noise = 1'b0;
    send(10'b11_1111_0000);
    repeat (7) @(negedge clk);  // now in DATA k=5
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ss_n !== 3'b111 || mosi !== 3'b000) begin
      errors++; $display("FAIL abort_pins: ss_n %b mosi %b, required 111 000", ss_n, mosi);
    end
    checks++;
    if ({done, rd_valid, busy} !== 9'b0) begin
      errors++; $display("FAIL abort_flags: done/rd_valid/busy got %b required 0", {done, rd_valid, busy});
    end
    checks++;
    if (rd_data[1] !== 8'h00) begin errors++; $display("FAIL abort_rd_data: got %h required 00", rd_data[1]); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 3'b111) begin errors++; $display("FAIL abort_release_ready: got %b required 111", cmd_ready); end
    for (int i = 0; i < 20; i++) begin
      if (done[1] !== 1'b0 || rd_valid[1] !== 1'b0 || ss_n[1] !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_quiet: %0d cycles with activity, required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_read_data();
    test_back_to_back();
    test_miso_ofs();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
